// File: rtl/if_align_buffer.sv
// if_align_buffer: instruction-fetch alignment buffer.
// Repacks word-aligned 32-bit fetch words into one instruction per decode
// beat ({id_pc, id_instr}). The buffer is a small shift register of
// halfwords: hw[0] is the oldest halfword. A pop removes the instruction at
// the front. A push appends new halfwords right after the ones that remain.
//
// Build option: define IF_ALIGN_RVC_EN to enable RV32C support. This covers
// 16-bit instructions, halfword-aligned PCs and the drop_low realignment.
// With the macro undefined, every instruction is 32-bit. The buffer then
// behaves as a 2-entry word FIFO and the PC advances by 4.
module if_align_buffer #(
  parameter int          HW_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_word,
  output logic        fetch_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_compressed
);

  localparam int CW = $clog2(HW_DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;

  logic [15:0] hw_q [HW_DEPTH];
  logic [15:0] hw_d [HW_DEPTH];
  cnt_t        count_q, count_d;
  cnt_t        base;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_target;
  logic        drop_now;
  logic        drop_next;
  logic        is16;
  logic [1:0]  need;
  logic        push, pop;
  logic [1:0]  push_hw, pop_hw;
  logic        unused_bits;

`ifdef IF_ALIGN_RVC_EN
  logic drop_low_q;

  assign is16            = (hw_q[0][1:0] != 2'b11);
  assign drop_now        = drop_low_q;
  assign redirect_target = {redirect_pc[31:1], 1'b0};
  assign drop_next       = redirect_valid ? redirect_pc[1] : (drop_low_q && !push);
  assign unused_bits     = redirect_pc[0];

  // drop_low: skip the low halfword of the first word fetched after a
  // realignment to an odd halfword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_low_q <= RESET_PC[1];
    else     drop_low_q <= drop_next;
  end
`else
  assign is16            = 1'b0;
  assign drop_now        = 1'b0;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign drop_next       = 1'b0;
  assign unused_bits     = ^{redirect_pc[1:0], drop_next};
`endif

  // The length of the front instruction determines how many halfwords a
  // complete beat needs.
  assign need     = is16 ? 2'd1 : 2'd2;
  assign id_valid = (count_q >= cnt_t'(need)) && !redirect_valid;

  // fetch_ready uses the pre-pop count. This keeps the buffer from
  // overflowing even when no pop happens in the same cycle.
  assign fetch_ready = (count_q <= cnt_t'(HW_DEPTH - 2));

  assign push    = fetch_valid && fetch_ready && !redirect_valid;
  assign pop     = id_valid && id_ready;
  assign pop_hw  = pop ? need : 2'd0;
  assign push_hw = !push ? 2'd0 : (drop_now ? 2'd1 : 2'd2);

  assign id_pc         = pc_q;
  assign id_instr      = !id_valid ? 32'h0 :
                         is16      ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign id_compressed = id_valid && is16;

  // Next buffer contents: first shift out the popped halfwords, then write
  // the pushed halfwords just behind the surviving ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    hw_d = hw_q;
    base = count_q - cnt_t'(pop_hw);
    if (pop_hw == 2'd1) begin
      for (int i = 0; i < HW_DEPTH - 1; i++) hw_d[i] = hw_q[i+1];
    end else if (pop_hw == 2'd2) begin
      for (int i = 0; i < HW_DEPTH - 2; i++) hw_d[i] = hw_q[i+2];
    end
    for (int i = 0; i < HW_DEPTH; i++) begin
      if (push_hw == 2'd1) begin
        if (cnt_t'(i) == base) hw_d[i] = fetch_word[31:16];
      end else if (push_hw == 2'd2) begin
        if (cnt_t'(i) == base)              hw_d[i] = fetch_word[15:0];
        if (cnt_t'(i) == base + cnt_t'(1))  hw_d[i] = fetch_word[31:16];
      end
    end
  end

  // Next count and PC. A redirect overrides both the push and the pop.
  always_comb begin
    count_d = count_q - cnt_t'(pop_hw) + cnt_t'(push_hw);
    pc_d    = pc_q + {29'd0, pop_hw, 1'b0};
    if (redirect_valid) begin
      count_d = '0;
      pc_d    = redirect_target;
    end
  end

  // Control state: occupancy and the PC of the front instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  // Halfword storage. Only the first count_q entries are ever read.
  // NOTE: the storage array has no reset; count_q alone qualifies which entries are live.
  always_ff @(posedge clk) begin
    hw_q <= hw_d;
  end

endmodule

// File: tb/tb_if_align_buffer.sv
// Self-checking bench for if_align_buffer.
// The reference model is a queue of halfwords plus a PC. A beat is the
// front instruction of the queue, and its length is decoded from the
// halfword's low bits. The RVC behaviour follows IF_ALIGN_RVC_EN, so the same
// bench works for both builds.
module tb_if_align_buffer;

  localparam int          HW_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_ALIGN_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_word;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_compressed;

  if_align_buffer #(.HW_DEPTH(HW_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_word     (fetch_word),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_compressed  (id_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [15:0] mq [$];
  logic [31:0] mpc;
  bit          mdrop;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = RESET_PC;
    mdrop = RVC && RESET_PC[1];
  endtask

  // One clock cycle. The task drives the inputs at the negedge, compares the
  // DUT outputs with the model, then advances the model at the posedge.
  task automatic step(input bit fv, input logic [31:0] fw, input bit rv,
                      input logic [31:0] rpc, input bit rdy);
    bit is16, v, fr;
    int need;
    fetch_valid    = fv;
    fetch_word     = fw;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
    is16 = RVC && (mq.size() >= 1) && (mq[0][1:0] != 2'b11);
    need = is16 ? 1 : 2;
    v    = !rv && (mq.size() >= need);
    fr   = (mq.size() <= HW_DEPTH - 2);
    check("fetch_ready", {31'd0, fetch_ready}, {31'd0, fr});
    check("id_valid",    {31'd0, id_valid},    {31'd0, v});
    check("id_pc",       id_pc,                mpc);
    if (v) begin
      check("id_instr", id_instr, is16 ? {16'h0, mq[0]} : {mq[1], mq[0]});
      check("id_compressed", {31'd0, id_compressed}, {31'd0, is16});
    end
    @(posedge clk);
    if (rv) begin
      mq.delete();
      mpc   = RVC ? {rpc[31:1], 1'b0} : {rpc[31:2], 2'b00};
      mdrop = RVC && rpc[1];
    end else begin
      if (v && rdy) begin
        repeat (need) void'(mq.pop_front());
        mpc = mpc + 32'(2 * need);
      end
      if (fv && fr) begin
        if (mdrop) begin
          mq.push_back(fw[31:16]);
          mdrop = 1'b0;
        end else begin
          mq.push_back(fw[15:0]);
          mq.push_back(fw[31:16]);
        end
      end
    end
    @(negedge clk);
  endtask

  // Compare the presented beat with fixed values, without advancing the clock.
  task automatic peek(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                      input bit comp);
    fetch_valid    = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    #1;
    check({tag, ".valid"}, {31'd0, id_valid},      32'd1);
    check({tag, ".pc"},    id_pc,                  pc);
    check({tag, ".instr"}, id_instr,               instr);
    check({tag, ".comp"},  {31'd0, id_compressed}, {31'd0, comp});
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    rst            = 1'b1;
    fetch_valid    = 1'b0;
    fetch_word     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset.id_valid",      {31'd0, id_valid},      32'd0);
    check("reset.id_pc",         id_pc,                  RESET_PC);
    check("reset.id_instr",      id_instr,               32'd0);
    check("reset.id_compressed", {31'd0, id_compressed}, 32'd0);
    check("reset.fetch_ready",   {31'd0, fetch_ready},   32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Two 32-bit instructions. Both modes present these identically.
    step(1'b1, 32'h00A0_0093, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0010_8113, 1'b0, 32'h0, 1'b0);
    peek("beat0", 32'h0, 32'h00A0_0093, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    peek("beat1", 32'h4, 32'h0010_8113, 1'b0);
    drain(2);

    // Two C.LI instructions packed in one word.
    step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h4501_4505, 1'b0, 32'h0, 1'b1);
    drain(3);

    // A 16-bit instruction, then a 32-bit instruction that straddles the next word.
    step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0093_4505, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hABCD_0010, 1'b0, 32'h0, 1'b1);
    drain(4);

    // Redirect to a halfword-aligned target while the buffer still holds data.
    step(1'b1, 32'h1111_1505, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h2222_3333, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h5555_6666, 1'b1, 32'h0000_0102, 1'b1);
    step(1'b1, 32'h4505_1234, 1'b0, 32'h0, 1'b0);
    peek("redir", RVC ? 32'h0000_0102 : 32'h0000_0100,
         RVC ? 32'h0000_4505 : 32'h4505_1234, RVC);
    drain(3);

    // Hold id_ready low with fetch_valid active, then release and drain.
    step(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0013_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
    fetch_valid = 1'b1;
    id_ready    = 1'b0;
    #1;
    check("stall.fetch_ready", {31'd0, fetch_ready}, 32'd0);
    drain(6);

    // Wrap the PC around the top of the address space.
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 32'h00A0_0093, 1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0010_8113, 1'b0, 32'h0, 1'b1);
    drain(3);

    // Assert reset between clock edges; the outputs must react without an edge.
    step(1'b1, 32'h0093_4505, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0010_8113, 1'b0, 32'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.id_valid",      {31'd0, id_valid},      32'd0);
    check("midrst.id_pc",         id_pc,                  RESET_PC);
    check("midrst.id_instr",      id_instr,               32'd0);
    check("midrst.id_compressed", {31'd0, id_compressed}, 32'd0);
    check("midrst.fetch_ready",   {31'd0, fetch_ready},   32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h00A0_0093, 1'b0, 32'h0, 1'b1);
    peek("postrst", RESET_PC, 32'h00A0_0093, 1'b0);
    drain(2);

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 24) == 0,
           $urandom, $urandom_range(0, 2) != 0);
    end
    drain(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_align_buffer.md
Name: if_align_buffer

Overview:
- Instruction-fetch alignment buffer, between the instruction memory port and the IF/ID pipeline register.
- Accepts a stream of word-aligned 32-bit fetch words and repacks them into one instruction per output beat, as {pc, instruction}.
- The output beat is exactly the payload of the decode-stage state.
- Handles RV32C 16-bit instructions and 32-bit instructions that straddle a word boundary; flushes and realigns on redirect (branch/jump/trap).

Parameters:
- HW_DEPTH, 4, halfword buffer capacity (minimum 4, must be even).
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- fetch_valid, input, 1, fetch_word is valid this cycle.
- fetch_word, input, 32, little-endian instruction word; low halfword first.
- fetch_ready, output, 1, buffer can accept a word (count <= HW_DEPTH-2).
- redirect_valid, input, 1, flush and restart at redirect_pc.
- redirect_pc, input, 32, new PC; bit 0 ignored (treated as 0).
- id_valid, output, 1, a complete instruction is presented.
- id_ready, input, 1, decode stage consumes the instruction.
- id_pc, output, 32, PC of the presented instruction.
- id_instr, output, 32, instruction; for 16-bit instructions, [31:16] = 0.
- id_compressed, output, 1, presented instruction is 16-bit.

Behaviour:
- State: halfword array hw[0..HW_DEPTH-1] (hw[0] = oldest), count 0..HW_DEPTH, pc_q, drop_low flag.
- Reset (async): count=0, pc_q=RESET_PC, drop_low=RESET_PC[1], hw contents don't-care. Outputs during reset: id_valid=0, id_pc=RESET_PC, id_instr=0, id_compressed=0, fetch_ready=1.
- Push happens when fetch_valid && fetch_ready && !redirect_valid.
  - Normally appends two halfwords (low, then high); count += 2.
  - If drop_low=1: appends only the high halfword, count += 1, and drop_low clears.
- Instruction length: hw[0][1:0] != 2'b11 means 16-bit, otherwise 32-bit.
- id_valid is combinational from registered state:
  - count>=1 for a 16-bit instruction, count>=2 for a 32-bit instruction.
  - Forced 0 while redirect_valid=1.
- id_instr = {16'h0, hw[0]} for 16-bit; {hw[1], hw[0]} for 32-bit. id_pc = pc_q. Zero-latency presentation; no bubble between back-to-back instructions.
- Pop happens when id_valid && id_ready. It shifts out 1 or 2 halfwords and sets pc_q += 2 or 4 (mod 2^32; wraps 0xFFFF_FFFE -> 0x0000_0000).
- Push and pop in the same cycle:
  - Both take effect; new count = count + pushed - popped.
  - fetch_ready is evaluated on the pre-pop count, so count never exceeds HW_DEPTH.
- Redirect (highest priority):
  - Next cycle: count=0, pc_q={redirect_pc[31:1],1'b0}, drop_low=redirect_pc[1].
  - The fetch word and the pop in the redirect cycle are discarded.
  - The fetch unit must issue the next fetch at the word containing redirect_pc.
- A straddling 32-bit instruction (low half in the last halfword of one word) stalls with id_valid=0 until the next word arrives.
- id_valid, id_pc, id_instr and id_compressed are held stable while id_valid && !id_ready.
- No illegal-instruction checking; all-zero 16-bit encodings pass through.

Optional Feature:
- Macro: IF_ALIGN_RVC_EN.
- Defined: full behaviour above, including 16-bit instructions and halfword alignment.
- Undefined (RV32I only):
  - Every instruction is treated as 32-bit; id_compressed is tied to 0.
  - redirect_pc[1:0] is ignored and drop_low is removed.
  - Buffer degenerates to a 2-entry word FIFO; pc_q advances by 4.

Test Plan:
- Reset with RESET_PC=0, words 0x00A00093, 0x00108113 -> two beats: pc 0x0 instr 0x00A00093, pc 0x4 instr 0x00108113, compressed=0.
- Word 0x45014505 (two C.LI) -> beat pc 0x0 instr 0x00004505 compressed=1, then pc 0x2 instr 0x00004501 compressed=1.
- Word 0x00934505 then 0xABCD0010 -> pc 0x0 instr 0x4505 (16-bit); pc 0x2 instr 0x00100093 (straddle: id_valid=0 until the second word arrives); the 16-bit 0xABCD at pc 0x6 is output as id_instr=0x0000ABCD, id_compressed=1.
- redirect_pc=0x0000_0102 with buffer holding 3 halfwords, next word 0x4505_1234 -> count flushed; first beat pc 0x102 instr 0x00004505; 0x1234 never output.
- id_ready=0 for 5 cycles with continuous fetch_valid -> count saturates at HW_DEPTH, fetch_ready=0, outputs stable, no halfword lost on release.
- rst asserted mid-stream (between clock edges) -> outputs reach reset values immediately without a clock edge; first beat after release has pc RESET_PC.
